// File: rtl/pipe_pkg.sv
// Shared definitions for the in-order pipeline stage registers.
// Per-boundary widths, control-bit indices, skid FSM encoding.
package pipe_pkg;

  localparam int unsigned DEF_DATA_W = 32;

  localparam int unsigned IFID_CTRL_W  = 1;
  localparam int unsigned IFID_NUM_CH  = 2;
  localparam int unsigned IDEX_CTRL_W  = 9;
  localparam int unsigned IDEX_NUM_CH  = 4;
  localparam int unsigned EXMEM_CTRL_W = 5;
  localparam int unsigned EXMEM_NUM_CH = 4;
  localparam int unsigned MEMWB_CTRL_W = 2;
  localparam int unsigned MEMWB_NUM_CH = 2;

  localparam int unsigned CTRL_MEMWRITE = 0;
  localparam int unsigned CTRL_MEMREAD  = 1;
  localparam int unsigned CTRL_BRANCH   = 2;
  localparam int unsigned CTRL_MEMTOREG = 3;
  localparam int unsigned CTRL_REGWRITE = 4;

  // Encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/pipe_entry.sv
// One stage-register entry: W bits, clear beats load.
// Ports: clk_i, clr_i (sync zero), ld_i, d_i[W], q_o[W].
module pipe_entry #(
  parameter int unsigned W = 133
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      q_q <= '0;
    end else if (ld_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Flushable valid/ready pipeline stage with optional 2-entry skid.
// Ports: Clk_in, Rst_in, in_*/out_* handshake+bundle, flush, occupancy.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       CTRL_W      = EXMEM_CTRL_W,
  parameter int unsigned       DATA_W      = DEF_DATA_W,
  parameter int unsigned       NUM_CH      = EXMEM_NUM_CH,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit                SKID        = 1'b1
) (
  input  logic                     Clk_in,
  input  logic                     Rst_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [1:0]               occupancy
);

  localparam int unsigned DW = NUM_CH * DATA_W;
  localparam int unsigned EW = CTRL_W + DW;

  logic [1:0]    state_q, state_d;
  logic          rdy_q, rdy_d;
  logic          acc, drn;
  logic          main_ld, skid_ld, skid_clr;
  logic [EW-1:0] main_d, main_q, skid_q;

  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  // Single-register mode never reaches FULL: in MAIN an
  // accept implies out_ready, hence a simultaneous drain.
  if (SKID) begin : g_rdy_reg
    assign in_ready = rdy_q;
  end else begin : g_rdy_comb
    assign in_ready = out_ready | ~out_valid;
  end

  always_comb begin
    state_d  = state_q;
    main_ld  = 1'b0;
    skid_ld  = 1'b0;
    skid_clr = 1'b0;
    main_d   = {in_ctrl, in_data};
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (1'b1)
        (state_q == ST_EMPTY): begin
          if (acc) begin
            state_d = ST_MAIN;
            main_ld = 1'b1;
          end
        end
        (state_q == ST_MAIN): begin
          if (acc && drn) begin
            main_ld = 1'b1;
          end else if (acc) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (drn) begin
            state_d = ST_EMPTY;
          end
        end
        (state_q == ST_FULL): begin
          if (drn) begin
            state_d  = ST_MAIN;
            main_ld  = 1'b1;
            main_d   = skid_q;
            skid_clr = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  assign rdy_d = (state_d != ST_FULL);

  always_ff @(posedge Clk_in) begin
    if (Rst_in) begin
      state_q <= ST_EMPTY;
      rdy_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      rdy_q   <= rdy_d;
    end
  end

  pipe_entry #(.W(EW)) u_main (
    .clk_i (Clk_in),
    .clr_i (Rst_in),
    .ld_i  (main_ld),
    .d_i   (main_d),
    .q_o   (main_q)
  );

  if (SKID) begin : g_skid
    pipe_entry #(.W(EW)) u_skid (
      .clk_i (Clk_in),
      .clr_i (Rst_in | skid_clr),
      .ld_i  (skid_ld),
      .d_i   ({in_ctrl, in_data}),
      .q_o   (skid_q)
    );
  end else begin : g_noskid
    assign skid_q = '0;
  end

  assign out_ctrl  = out_valid ? main_q[EW-1 -: CTRL_W]
                               : CTRL_BUBBLE;
  assign out_data  = main_q[DW-1:0];
  assign occupancy = state_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: skid and single-register variants.
// Queue reference model per DUT plus directed literal checks.
module tb_pipe_stage_skid;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // DUT A: skid mode, 5 ctrl, 4 x 32 data
  logic         a_rst, a_iv, a_fl, a_or;
  logic [4:0]   a_ic;
  logic [127:0] a_id;
  logic         a_ir, a_ov;
  logic [4:0]   a_oc;
  logic [127:0] a_od;
  logic [1:0]   a_occ;

  pipe_stage_skid #(
    .CTRL_W(5), .DATA_W(32), .NUM_CH(4), .SKID(1'b1)
  ) dut_a (
    .Clk_in(clk), .Rst_in(a_rst),
    .in_valid(a_iv), .in_ready(a_ir),
    .in_ctrl(a_ic), .in_data(a_id),
    .flush(a_fl),
    .out_valid(a_ov), .out_ready(a_or),
    .out_ctrl(a_oc), .out_data(a_od),
    .occupancy(a_occ)
  );

  // DUT B: single register, 2 x 16 data
  logic         b_rst, b_iv, b_fl, b_or;
  logic [4:0]   b_ic;
  logic [31:0]  b_id;
  logic         b_ir, b_ov;
  logic [4:0]   b_oc;
  logic [31:0]  b_od;
  logic [1:0]   b_occ;

  pipe_stage_skid #(
    .CTRL_W(5), .DATA_W(16), .NUM_CH(2), .SKID(1'b0)
  ) dut_b (
    .Clk_in(clk), .Rst_in(b_rst),
    .in_valid(b_iv), .in_ready(b_ir),
    .in_ctrl(b_ic), .in_data(b_id),
    .flush(b_fl),
    .out_valid(b_ov), .out_ready(b_or),
    .out_ctrl(b_oc), .out_data(b_od),
    .occupancy(b_occ)
  );

  typedef logic [132:0] bun_t;
  bun_t        qa[$];
  bun_t        qb[$];
  logic [31:0] em_a[$];
  logic [31:0] em_b[$];

  task automatic chk(string nm, logic [127:0] act,
                     logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: FIFO of capacity 2 (A) or 1 (B).
  always @(posedge clk) begin : m_a
    bit acc, drn;
    acc = a_iv && (qa.size() < 2);
    drn = (qa.size() > 0) && a_or;
    if (a_rst) begin
      qa.delete();
    end else begin
      if (drn) em_a.push_back(qa[0][31:0]);
      if (a_fl) begin
        qa.delete();
      end else begin
        if (drn) void'(qa.pop_front());
        if (acc) qa.push_back({a_ic, a_id});
      end
    end
  end

  always @(posedge clk) begin : m_b
    bit acc, drn;
    acc = b_iv && ((qb.size() == 0) || b_or);
    drn = (qb.size() > 0) && b_or;
    if (b_rst) begin
      qb.delete();
    end else begin
      if (drn) em_b.push_back(qb[0][31:0]);
      if (b_fl) begin
        qb.delete();
      end else begin
        if (drn) void'(qb.pop_front());
        if (acc) qb.push_back({b_ic, 96'd0, b_id});
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("a_occ", a_occ, qa.size());
      chk("a_valid", a_ov, qa.size() > 0);
      chk("a_ready", a_ir, qa.size() < 2);
      if (qa.size() > 0) begin
        chk("a_ctrl", a_oc, qa[0][132:128]);
        chk("a_data", a_od, qa[0][127:0]);
      end else begin
        chk("a_bubble", a_oc, 0);
      end
      chk("b_occ", b_occ, qb.size());
      chk("b_valid", b_ov, qb.size() > 0);
      chk("b_ready", b_ir, (qb.size() == 0) || b_or);
      if (qb.size() > 0) begin
        chk("b_ctrl", b_oc, qb[0][132:128]);
        chk("b_data", b_od, qb[0][31:0]);
      end else begin
        chk("b_bubble", b_oc, 0);
      end
    end
  end

  int          nxt;
  bit          accp;
  int          hits;
  logic [15:0] v;

  initial begin
    a_rst = 1'b1; a_iv = 1'b1; a_fl = 1'b0; a_or = 1'b0;
    a_ic = 5'b11111; a_id = '1;
    b_rst = 1'b1; b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b0;
    b_ic = '0; b_id = '0;
    cyc();
    chk_en = 1'b1;
    cyc();
    chk("rst_valid", a_ov, 0);
    chk("rst_ctrl", a_oc, 5'b00000);
    chk("rst_occ", a_occ, 0);
    chk("rst_ready", a_ir, 1);
    chk("rst_data", a_od, 0);

    a_rst = 1'b0; b_rst = 1'b0;
    a_ic = 5'b10101; a_id = {96'd0, 32'hDEAD_BEEF};
    cyc();
    a_iv = 1'b0;
    chk("first_valid", a_ov, 1);
    chk("first_ctrl", a_oc, 5'b10101);
    chk("first_ch0", a_od[31:0], 32'hDEAD_BEEF);
    a_or = 1'b1;
    cyc();
    em_a.delete();

    // streaming
    for (int i = 1; i <= 8; i++) begin
      a_iv = 1'b1;
      a_ic = 5'(i);
      a_id = {96'd0, 32'(i)};
      cyc();
      chk("stream_lat", a_od[31:0], i);
      chk("stream_rdy", a_ir, 1);
    end
    a_iv = 1'b0;
    cyc();
    cyc();
    chk("stream_cnt", em_a.size(), 8);
    for (int i = 0; i < em_a.size() && i < 8; i++)
      chk("stream_ord", em_a[i], i + 1);
    em_a.delete();

    // stall into skid
    a_or = 1'b0; a_iv = 1'b1; a_ic = 5'b01010;
    a_id = {96'd0, 32'd10};
    cyc();
    chk("stall_occ1", a_occ, 1);
    a_id = {96'd0, 32'd11};
    cyc();
    chk("stall_occ2", a_occ, 2);
    chk("stall_rdy0", a_ir, 0);
    a_id = {96'd0, 32'd12};
    cyc();
    chk("stall_occ2b", a_occ, 2);
    chk("stall_hold", a_od[31:0], 10);
    a_or = 1'b1;
    cyc();
    chk("rel_occ1", a_occ, 1);
    chk("rel_out11", a_od[31:0], 11);
    cyc();
    a_iv = 1'b0;
    chk("rel_out12", a_od[31:0], 12);
    cyc();
    chk("rel_occ0", a_occ, 0);
    chk("rel_cnt", em_a.size(), 3);
    for (int i = 0; i < em_a.size() && i < 3; i++)
      chk("rel_ord", em_a[i], i + 10);
    em_a.delete();

    // flush in FULL
    a_or = 1'b0; a_iv = 1'b1; a_ic = 5'b00111;
    a_id = {96'd0, 32'd20};
    cyc();
    a_id = {96'd0, 32'd21};
    cyc();
    chk("fl_pre_occ", a_occ, 2);
    a_fl = 1'b1; a_id = {96'd0, 32'd99};
    cyc();
    a_fl = 1'b0; a_iv = 1'b0;
    chk("fl_valid", a_ov, 0);
    chk("fl_ctrl", a_oc, 5'b00000);
    chk("fl_occ", a_occ, 0);
    chk("fl_rdy", a_ir, 1);
    a_or = 1'b1;
    cyc();
    cyc();
    hits = 0;
    foreach (em_a[i]) if (em_a[i] == 32'd99) hits++;
    chk("fl_no99", hits, 0);

    // flush + reset together
    a_or = 1'b0; a_iv = 1'b1; a_id = {96'd0, 32'd30};
    cyc();
    a_fl = 1'b1; a_rst = 1'b1; a_id = {96'd0, 32'd31};
    cyc();
    chk("flrst_occ", a_occ, 0);
    chk("flrst_valid", a_ov, 0);
    a_fl = 1'b0; a_rst = 1'b0; a_iv = 1'b0;
    cyc();
    chk("flrst_drop", a_occ, 0);

    // mid-stream reset beats accept
    a_or = 1'b1; a_iv = 1'b1; a_id = {96'd0, 32'd40};
    cyc();
    a_id = {96'd0, 32'd41};
    cyc();
    a_rst = 1'b1; a_id = {96'd0, 32'd42};
    cyc();
    chk("mrst_occ", a_occ, 0);
    chk("mrst_data", a_od, 0);
    a_rst = 1'b0; a_iv = 1'b0;
    cyc();
    chk("mrst_drop", a_occ, 0);

    // single-register variant
    em_b.delete();
    b_or = 1'b0; b_iv = 1'b1; b_ic = 5'b00011;
    b_id = {16'hA001, 16'h0001};
    cyc();
    chk("b_full_rdy", b_ir, 0);
    b_iv = 1'b0; b_or = 1'b1;
    #1;
    chk("b_rel_rdy", b_ir, 1);
    nxt = 2;
    for (int c = 0;
         c < 40 && (nxt <= 4 || qb.size() > 0); c++) begin
      b_or = c[0];
      b_iv = (nxt <= 4);
      v = 16'(nxt);
      b_id = {16'hA000 | v, v};
      accp = b_iv && ((qb.size() == 0) || b_or);
      cyc();
      if (accp) nxt++;
    end
    b_iv = 1'b0; b_or = 1'b1;
    cyc();
    cyc();
    chk("b_cnt", em_b.size(), 4);
    for (int i = 0; i < em_b.size() && i < 4; i++) begin
      v = 16'(i + 1);
      chk("b_ord", em_b[i], {16'hA000 | v, v});
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
